keypad_mode_counter: RTL and testbench

Keypad front end that turns a 10-key one-hot keypad into a registered BCD digit with a key-present flag. Each new key press becomes a single-cycle strobe, and a 1:2 demux steers that strobe to one of two mode lines. Mode-0 strobes step a 3-stage toggle-flip-flop counter whose true and complement outputs serve as divided-down clock/status lines. The block sits between the keypad scanner and downstream mode logic.

---
 rtl/keypad_mode_counter_pkg.sv | 22 ++
 rtl/keypad_mode_counter_tff_cell.sv | 28 ++
 rtl/keypad_mode_counter.sv | 76 +++++++
 tb/tb_keypad_mode_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_mode_counter_pkg.sv
// Shared constants and the keypad priority encoder for keypad_mode_counter.
package keypad_mode_counter_pkg;

    localparam int unsigned KEY_COUNT = 10;
    localparam int unsigned BCD_W     = 4;

    // Highest pressed index wins; returns {valid, bcd}.
    function automatic logic [BCD_W:0] prio_encode(input logic [KEY_COUNT-1:0] key_vec);
        logic             valid;
        logic [BCD_W-1:0] bcd;
        valid = 1'b0;
        bcd   = '0;
        for (int i = 0; i < int'(KEY_COUNT); i++) begin
            if (key_vec[i]) begin
                valid = 1'b1;
                bcd   = BCD_W'(i);
            end
        end
        return {valid, bcd};
    endfunction

endpackage

// File: rtl/keypad_mode_counter_tff_cell.sv
// Single toggle flip-flop stage with true and complement outputs.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t_in,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/keypad_mode_counter.sv
// Keypad encoder with press-strobe detection, 1:2 mode demux and a T-FF counter
// stepped by mode-0 presses.
module keypad_mode_counter
    import keypad_mode_counter_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KEY_COUNT-1:0] key,
    input  logic                 sel,
    input  logic                 t,
    output logic [BCD_W-1:0]     bcd,
    output logic                 key_valid,
    output logic [1:0]           mode_out,
    output logic [CNT_W-1:0]     q,
    output logic [CNT_W-1:0]     qbar
);

    logic [BCD_W:0]   enc_d;
    logic [BCD_W-1:0] bcd_q;
    logic             valid_q;
    logic             valid_dly_q;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             press;
    logic [CNT_W-1:0] tog;

    always_comb begin
        enc_d = prio_encode(key);
    end

    // A press needs an idle cycle before it; key-to-key changes keep valid high.
    always_comb begin
        press  = valid_q & ~valid_dly_q;
        mode_d = 2'b00;
        if (press) begin
            mode_d = sel ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            valid_dly_q <= 1'b0;
            mode_q      <= 2'b00;
        end else begin
            bcd_q       <= enc_d[BCD_W-1:0];
            valid_q     <= enc_d[BCD_W];
            valid_dly_q <= valid_q;
            mode_q      <= mode_d;
        end
    end

    assign tog[0] = t & press & ~sel;

    for (genvar k = 1; k < int'(CNT_W); k++) begin : g_tog
        assign tog[k] = tog[k-1] & q[k-1];
    end

    for (genvar g = 0; g < int'(CNT_W); g++) begin : g_stage
        tff_cell u_tff (
            .clk  (clk),
            .reset(reset),
            .t_in (tog[g]),
            .q    (q[g]),
            .qbar (qbar[g])
        );
    end

    assign bcd       = bcd_q;
    assign key_valid = valid_q;
    assign mode_out  = mode_q;

endmodule

// File: tb/tb_keypad_mode_counter.sv
// Self-checking bench for keypad_mode_counter: vector table through a scoreboard
// queue, plus hand-written reset sequences.
module tb_keypad_mode_counter;

    logic       clk;
    logic       reset;
    logic [9:0] key;
    logic       sel;
    logic       t;
    logic [3:0] bcd;
    logic       key_valid;
    logic [1:0] mode_out;
    logic [2:0] q;
    logic [2:0] qbar;

    int checks = 0;
    int errors = 0;

    keypad_mode_counter #(.CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .key      (key),
        .sel      (sel),
        .t        (t),
        .bcd      (bcd),
        .key_valid(key_valid),
        .mode_out (mode_out),
        .q        (q),
        .qbar     (qbar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] key;
        logic       sel;
        logic       t;
        logic [4:0] code;
        logic [1:0] mode;
        logic [2:0] q;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [9:0] k, input logic s, input logic tt,
                                input logic [4:0] c, input logic [1:0] m,
                                input logic [2:0] qq);
        vec_t v;
        v.key  = k;
        v.sel  = s;
        v.t    = tt;
        v.code = c;
        v.mode = m;
        v.q    = qq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] code, input logic [1:0] m,
                             input logic [2:0] qq);
        check({tag, ".code"}, {27'd0, key_valid, bcd}, {27'd0, code});
        check({tag, ".mode"}, {30'd0, mode_out}, {30'd0, m});
        check({tag, ".q"}, {29'd0, q}, {29'd0, qq});
        check({tag, ".qbar"}, {29'd0, qbar}, {29'd0, ~qq});
    endtask

    initial begin
        vec_t e;
        reset = 1'b0;
        key   = '0;
        sel   = 1'b0;
        t     = 1'b0;

        // key[0] held 5 cycles
        vecs.push_back(mk(10'h001, 0, 1, 5'b10000, 2'b00, 3'b000));
        vecs.push_back(mk(10'h001, 0, 1, 5'b10000, 2'b01, 3'b001));
        vecs.push_back(mk(10'h001, 0, 1, 5'b10000, 2'b00, 3'b001));
        vecs.push_back(mk(10'h001, 0, 1, 5'b10000, 2'b00, 3'b001));
        vecs.push_back(mk(10'h001, 0, 1, 5'b10000, 2'b00, 3'b001));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b001));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b001));
        // key[1]
        vecs.push_back(mk(10'h002, 0, 1, 5'b10001, 2'b00, 3'b001));
        vecs.push_back(mk(10'h002, 0, 1, 5'b10001, 2'b01, 3'b010));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b010));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b010));
        // key[9]
        vecs.push_back(mk(10'h200, 0, 1, 5'b11001, 2'b00, 3'b010));
        vecs.push_back(mk(10'h200, 0, 1, 5'b11001, 2'b01, 3'b011));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b011));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b011));
        // key[3]+key[7], then straight to key[5]: one press only
        vecs.push_back(mk(10'h088, 0, 1, 5'b10111, 2'b00, 3'b011));
        vecs.push_back(mk(10'h088, 0, 1, 5'b10111, 2'b01, 3'b100));
        vecs.push_back(mk(10'h088, 0, 1, 5'b10111, 2'b00, 3'b100));
        vecs.push_back(mk(10'h020, 0, 1, 5'b10101, 2'b00, 3'b100));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b100));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b100));
        // mode 1 press
        vecs.push_back(mk(10'h004, 1, 1, 5'b10010, 2'b00, 3'b100));
        vecs.push_back(mk(10'h004, 1, 1, 5'b10010, 2'b10, 3'b100));
        vecs.push_back(mk(10'h000, 1, 1, 5'b00000, 2'b00, 3'b100));
        vecs.push_back(mk(10'h000, 1, 1, 5'b00000, 2'b00, 3'b100));
        // mode 0 press with t=0
        vecs.push_back(mk(10'h010, 0, 0, 5'b10100, 2'b00, 3'b100));
        vecs.push_back(mk(10'h010, 0, 0, 5'b10100, 2'b01, 3'b100));
        vecs.push_back(mk(10'h000, 0, 0, 5'b00000, 2'b00, 3'b100));
        vecs.push_back(mk(10'h000, 0, 0, 5'b00000, 2'b00, 3'b100));
        // single-cycle presses up to 111, then wrap
        vecs.push_back(mk(10'h040, 0, 1, 5'b10110, 2'b00, 3'b100));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b01, 3'b101));
        vecs.push_back(mk(10'h040, 0, 1, 5'b10110, 2'b00, 3'b101));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b01, 3'b110));
        vecs.push_back(mk(10'h040, 0, 1, 5'b10110, 2'b00, 3'b110));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b01, 3'b111));
        vecs.push_back(mk(10'h100, 0, 1, 5'b11000, 2'b00, 3'b111));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b01, 3'b000));
        vecs.push_back(mk(10'h000, 0, 1, 5'b00000, 2'b00, 3'b000));

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset", 5'b00000, 2'b00, 3'b000);

        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            key = vecs[i].key;
            sel = vecs[i].sel;
            t   = vecs[i].t;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_all($sformatf("vec%0d", i), e.code, e.mode, e.q);
            end
        end

        // Reset asserted mid-cycle while a key is held and a strobe is out
        @(negedge clk);
        key = 10'h100;
        sel = 1'b0;
        t   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("pre_rst", 5'b11000, 2'b01, 3'b001);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_clr", 5'b00000, 2'b00, 3'b000);

        // Release with key still held: exactly one strobe, two edges later
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("rel_e1", 5'b11000, 2'b00, 3'b000);
        @(posedge clk);
        #1;
        check_all("rel_e2", 5'b11000, 2'b01, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("rel_hold%0d", i), 5'b11000, 2'b00, 3'b001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
